// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 3-sample majority voting and valid/ready output
module uart_rx_cfg #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);
  localparam int BIT_TICKS = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int TW        = $clog2(BIT_TICKS);
  localparam logic [TW-1:0] T_LAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] T_SM0  = TW'(HALF - 1);
  localparam logic [TW-1:0] T_SM1  = TW'(HALF);
  localparam logic [TW-1:0] T_SPT  = TW'(HALF + 1);
  localparam logic [3:0] B_DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] B_SLAST = 4'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [1:0]             smp_q, smp_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bad_q, par_bad_d;
  logic                   stop_bad_q, stop_bad_d;
  logic                   nz_q, nz_d;
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   break_det_q, break_det_d;
  logic                   meta_q, s_rxd_q, hist_q;
  logic                   maj, spt, wrap, brk, load, drop;

  assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & s_rxd_q) | (smp_q[1] & s_rxd_q);
  assign spt  = tick_q == T_SPT;
  assign wrap = tick_q == T_LAST;
  assign brk  = ~nz_q;
  assign load = done_q & ~brk & (~rx_valid_q | rx_ready);
  assign drop = done_q & ~brk & rx_valid_q & ~rx_ready;

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_det_q;
  assign busy       = state_q != S_IDLE;

  // Two-flop synchroniser plus edge history; all idle high so reset release never looks like a start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      s_rxd_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      meta_q  <= rxd;
      s_rxd_q <= meta_q;
      hist_q  <= s_rxd_q;
    end
  end

  // Frame FSM, bit timer, shifter and output holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      smp_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      nz_q         <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      smp_q        <= smp_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      nz_q         <= nz_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      break_det_q  <= break_det_d;
    end
  end

  // Next-state: start detection, per-bit majority sampling, early exit at the last stop sample
  always_comb begin
    state_d    = state_q;
    tick_d     = (state_q == S_IDLE || wrap) ? '0 : tick_q + 1'b1;
    smp_d      = {tick_q == T_SM1 ? s_rxd_q : smp_q[1], tick_q == T_SM0 ? s_rxd_q : smp_q[0]};
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    nz_d       = nz_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hist_q && !s_rxd_q) begin
          state_d    = S_START;
          bit_d      = '0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
          nz_d       = 1'b0;
        end
      end
      S_START: begin
        if (spt && maj) state_d = S_IDLE;
        else if (wrap) state_d = S_DATA;
      end
      S_DATA: begin
        if (spt) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          nz_d    = nz_q | maj;
        end
        if (wrap) begin
          bit_d = (bit_q == B_DLAST) ? '0 : bit_q + 1'b1;
          if (bit_q == B_DLAST) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (spt) begin
          par_bad_d = (^shift_q ^ maj) != PAR_ODD;
          nz_d      = nz_q | maj;
        end
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (spt) begin
          stop_bad_d = stop_bad_q | ~maj;
          nz_d       = nz_q | maj;
        end
        if (spt && bit_q == B_SLAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (wrap) begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output handshake: load on completion unless a held word is still unread, then drop and flag overrun
  always_comb begin
    rx_valid_d   = load | (rx_valid_q & ~rx_ready);
    rx_data_d    = load ? shift_q : rx_data_q;
    parity_err_d = load ? par_bad_q : parity_err_q;
    frame_err_d  = load ? stop_bad_q : frame_err_q;
    overrun_d    = drop;
    break_det_d  = done_q & brk;
  end
endmodule
